// File: rtl/spi_regfile_if.sv
// SPI pin bundle between an external SPI master and the register file slave.
interface spi_regfile_if;
    logic SCK;
    logic SSEL;
    logic MOSI;
    logic MISO;

    modport master (output SCK, output SSEL, output MOSI, input MISO);
    modport slave  (input SCK, input SSEL, input MOSI, output MISO);
endinterface

// File: rtl/spi_regfile.sv
// SPI slave register file: fixed-length checksummed frames commit NW write
// registers atomically and return a snapshot of NR read registers; a watchdog
// zeroes the write registers when good frames stop arriving.
//
// state    | meaning
// S_IDLE   | no frame in progress; SCK ignored, MISO held low
// S_ACTIVE | frame in progress since the last detected SSEL fall
module spi_regfile #(
    parameter int NW          = 4,
    parameter int NR          = 4,
    parameter int SAMPLE_FALL = 0,
    parameter int WDT_CYCLES  = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    spi_regfile_if.slave        spi,
    output logic [16*NW-1:0]    wr_regs,
    input  logic [16*NR-1:0]    rd_regs,
    output logic                frame_ok,
    output logic                frame_err,
    output logic                wdt_expired
);

    localparam int NMAX = (NW > NR) ? NW : NR;
    localparam int L    = 2 * NMAX + 1;
    localparam logic [4:0] LAST_IDX  = 5'(L - 1);
    localparam logic [4:0] FRAME_LEN = 5'(L);
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state_q, state_d;

    logic [2:0]          sck_sync, ssel_sync;
    logic                sck_rise, sck_fall, ssel_rise, ssel_fall;
    logic                sample_edge, shift_edge;
    logic                selected, frame_done, miso;

    logic [2:0]          bitcnt;
    logic [4:0]          bytecnt, bytecnt_inc;
    logic [6:0]          rx_shift;
    logic [7:0]          rx_byte, rx_csum, rx_last;
    logic [7:0]          tx_shift;
    logic [16*NR-1:0]    snap;
    logic [16*NW-1:0]    staging;
    logic                frame_good;
    logic [WDT_W-1:0]    wdt_cnt;

    // TX byte idx of a frame built from read-register image s; the last byte
    // is the XOR of all data bytes, which equals the XOR of every reg byte.
    function automatic logic [7:0] tx_byte(input logic [16*NR-1:0] s, input logic [4:0] idx);
        logic [7:0] b;
        logic [7:0] c;
        b = 8'h00;
        c = 8'h00;
        for (int k = 0; k < NR; k++) begin
            c = c ^ s[16*k +: 8] ^ s[16*k+8 +: 8];
            if (idx == 5'(2*k))     b = s[16*k +: 8];
            if (idx == 5'(2*k + 1)) b = s[16*k+8 +: 8];
        end
        if (idx == LAST_IDX) b = c;
        return b;
    endfunction

    // Synchronizers keep sampling through rst so a select already low when
    // rst drops is not mistaken for a fresh falling edge.
    always_ff @(posedge clk) begin
        sck_sync  <= {sck_sync[1:0], spi.SCK};
        ssel_sync <= {ssel_sync[1:0], spi.SSEL};
    end

    assign sck_rise    = sck_sync[1] & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1] & sck_sync[2];
    assign ssel_rise   = ssel_sync[1] & ~ssel_sync[2];
    assign ssel_fall   = ~ssel_sync[1] & ssel_sync[2];
    assign sample_edge = (SAMPLE_FALL != 0) ? sck_fall : sck_rise;
    assign shift_edge  = (SAMPLE_FALL != 0) ? sck_rise : sck_fall;

    assign rx_byte     = {rx_shift, spi.MOSI};
    assign bytecnt_inc = (bytecnt == 5'd31) ? bytecnt : bytecnt + 5'd1;
    assign frame_good  = (bytecnt == FRAME_LEN) && (bitcnt == 3'd0) && (rx_last == rx_csum);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: a falling select (re)starts a frame, a rising one ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (ssel_fall) state_d = S_ACTIVE;
            S_ACTIVE: if (ssel_rise) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        selected   = (state_q == S_ACTIVE);
        frame_done = selected && ssel_rise;
        miso       = selected ? tx_shift[7] : 1'b0;
    end

    assign spi.MISO = miso;

    // Frame datapath: bit/byte counting, RX staging and checksum, TX shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt   <= '0;
            bytecnt  <= '0;
            rx_shift <= '0;
            rx_csum  <= '0;
            rx_last  <= '0;
            tx_shift <= '0;
            snap     <= '0;
            staging  <= '0;
        end else if (ssel_fall) begin
            bitcnt   <= '0;
            bytecnt  <= '0;
            rx_csum  <= '0;
            snap     <= rd_regs;
            tx_shift <= tx_byte(rd_regs, 5'd0);
        end else if (selected && sample_edge) begin
            rx_shift <= {rx_shift[5:0], spi.MOSI};
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
                bytecnt  <= bytecnt_inc;
                tx_shift <= tx_byte(snap, bytecnt_inc);
                if (bytecnt < LAST_IDX) begin
                    rx_csum <= rx_csum ^ rx_byte;
                    for (int k = 0; k < NW; k++) begin
                        if (bytecnt == 5'(2*k))     staging[16*k +: 8]   <= rx_byte;
                        if (bytecnt == 5'(2*k + 1)) staging[16*k+8 +: 8] <= rx_byte;
                    end
                end
                if (bytecnt == LAST_IDX) rx_last <= rx_byte;
            end
        end else if (selected && shift_edge && bitcnt != 3'd0) begin
            tx_shift <= {tx_shift[6:0], 1'b0};
        end
    end

    // Commit, frame status pulses and watchdog; a commit outranks a trip.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_regs     <= '0;
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            wdt_expired <= 1'b1;
            wdt_cnt     <= '0;
        end else begin
            frame_ok  <= frame_done && frame_good;
            frame_err <= frame_done && !frame_good;
            if (frame_done && frame_good) begin
                wr_regs     <= staging;
                wdt_cnt     <= '0;
                wdt_expired <= 1'b0;
            end else begin
                if (wdt_cnt != WDT_W'(WDT_CYCLES)) wdt_cnt <= wdt_cnt + 1'b1;
                if (wdt_cnt >= WDT_W'(WDT_CYCLES - 1)) begin
                    wdt_expired <= 1'b1;
                    wr_regs     <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile (NW=NR=2, L=5, WDT_CYCLES=1000) with
// queue-based scoreboards for MISO bytes and frame_ok/frame_err events.
module tb_spi_regfile;
    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wr_regs;
    logic [31:0] rd_regs;
    logic        frame_ok, frame_err, wdt_expired;

    spi_regfile_if spi();

    spi_regfile #(.NW(2), .NR(2), .SAMPLE_FALL(0), .WDT_CYCLES(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi         (spi),
        .wr_regs     (wr_regs),
        .rd_regs     (rd_regs),
        .frame_ok    (frame_ok),
        .frame_err   (frame_err),
        .wdt_expired (wdt_expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          ok;
        logic [31:0] wr;
    } ev_t;

    ev_t         ev_q[$];
    logic [7:0]  miso_q[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  m_shift = 8'h00;
    int          m_bits = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input bit ok, input logic [31:0] wr);
        ev_t e;
        e.ok = ok;
        e.wr = wr;
        ev_q.push_back(e);
    endtask

    task automatic expect_miso(input logic [47:0] d, input int n);
        for (int i = 0; i < n; i++) miso_q.push_back(d[47-8*i -: 8]);
    endtask

    task automatic ssel_low();
        @(negedge clk) spi.SSEL = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic ssel_high();
        repeat (4) @(negedge clk);
        spi.SSEL = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            spi.MOSI = b[i];
            repeat (HALF) @(negedge clk);
            spi.SCK = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.SCK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [47:0] d, input int n);
        ssel_low();
        for (int i = 0; i < n; i++) send_byte(d[47-8*i -: 8]);
        ssel_high();
    endtask

    // MISO monitor: collects a byte per 8 SCK rises, restarting on select.
    always @(posedge spi.SCK or negedge spi.SSEL) begin
        if (spi.SCK) begin
            m_shift = {m_shift[6:0], spi.MISO};
            m_bits++;
            if (m_bits == 8) begin
                m_bits = 0;
                if (miso_q.size() == 0) begin
                    check("miso_unexpected_byte", {24'h0, m_shift}, 32'hxxxx_xxxx);
                end else begin
                    check("miso_byte", {24'h0, m_shift}, {24'h0, miso_q.pop_front()});
                end
            end
        end else begin
            m_bits = 0;
        end
    end

    // Event monitor: every frame_ok/frame_err pulse must match the next expectation.
    always @(negedge clk) begin
        if (frame_ok || frame_err) begin
            if (ev_q.size() == 0) begin
                check("unexpected_pulse", {30'h0, frame_ok, frame_err}, 32'h0);
            end else begin
                ev_t e;
                e = ev_q.pop_front();
                check("pulse_kind", {30'h0, frame_ok, frame_err}, {30'h0, e.ok, !e.ok});
                check("wr_regs_at_pulse", wr_regs, e.wr);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        spi.SCK  = 1'b0;
        spi.SSEL = 1'b1;
        spi.MOSI = 1'b0;
        rd_regs  = 32'hBEEF_1234;
        repeat (5) @(negedge clk);
        check("rst_wr_regs", wr_regs, 32'h0);
        check("rst_wdt_expired", {31'h0, wdt_expired}, 32'h1);
        check("rst_miso", {31'h0, spi.MISO}, 32'h0);
        check("rst_pulses", {30'h0, frame_ok, frame_err}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // good frame
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b1, 32'hABCD_1234);
        send_frame(48'h34_12_CD_AB_40_00, 5);
        check("good_wr_regs", wr_regs, 32'hABCD_1234);
        check("good_wdt_clear", {31'h0, wdt_expired}, 32'h0);

        // bad checksum
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b0, 32'hABCD_1234);
        send_frame(48'h34_12_CD_AB_41_00, 5);

        // short frame after a fresh commit
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b1, 32'hABCD_1234);
        send_frame(48'h34_12_CD_AB_40_00, 5);
        expect_miso(48'h34_12_EF_BE_00_00, 4);
        expect_ev(1'b0, 32'hABCD_1234);
        send_frame(48'h11_22_33_44_00_00, 4);

        // long frame whose first five bytes would be valid
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b1, 32'hABCD_1234);
        send_frame(48'h34_12_CD_AB_40_00, 5);
        expect_miso(48'h34_12_EF_BE_77_00, 6);
        expect_ev(1'b0, 32'hABCD_1234);
        send_frame(48'h11_22_33_44_44_00, 6);
        check("long_wr_regs", wr_regs, 32'hABCD_1234);

        // snapshot: rd_regs cleared after byte 0 must not reach MISO
        rd_regs = 32'h1234_BEEF;
        expect_miso(48'hEF_BE_34_12_77_00, 5);
        expect_ev(1'b1, 32'h4433_2211);
        ssel_low();
        send_byte(8'h11);
        rd_regs = 32'h0;
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h44);
        ssel_high();

        // watchdog
        repeat (900) @(negedge clk);
        check("wdt_not_yet", {31'h0, wdt_expired}, 32'h0);
        check("wdt_not_yet_wr", wr_regs, 32'h4433_2211);
        repeat (200) @(negedge clk);
        check("wdt_tripped", {31'h0, wdt_expired}, 32'h1);
        check("wdt_wr_zero", wr_regs, 32'h0);
        rd_regs = 32'hBEEF_1234;
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b1, 32'hABCD_1234);
        send_frame(48'h34_12_CD_AB_40_00, 5);
        check("wdt_recover", {31'h0, wdt_expired}, 32'h0);

        // reset in the middle of a frame
        expect_miso(48'h34_12_00_00_00_00, 2);
        ssel_low();
        send_byte(8'h55);
        send_byte(8'h66);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_wr_regs", wr_regs, 32'h0);
        check("midrst_wdt", {31'h0, wdt_expired}, 32'h1);
        check("midrst_miso", {31'h0, spi.MISO}, 32'h0);
        spi.SSEL = 1'b1;
        repeat (8) @(negedge clk);
        expect_miso(48'h34_12_EF_BE_77_00, 5);
        expect_ev(1'b1, 32'h0403_0201);
        send_frame(48'h01_02_03_04_04_00, 5);
        check("after_rst_wr_regs", wr_regs, 32'h0403_0201);

        repeat (20) @(negedge clk);
        check("pending_events", ev_q.size(), 32'h0);
        check("pending_miso", miso_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
